// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus a WIDTH-cycle shift-add multiply.
// Dout and status flags are registered; done/err pulse on each result.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alus,
    input  logic [WIDTH-1:0] ac_n,
    input  logic [WIDTH-1:0] bus_n,
    output logic [WIDTH-1:0] Dout,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam int M  = WIDTH - 1;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0]   res_w;
    logic [WIDTH:0]     sum_w;
    logic [2*WIDTH-1:0] prod_w;
    logic               c_w, v_w, def_w;

    // Single-cycle result and flags for the currently selected operation
    always_comb begin
        res_w = '0;
        sum_w = '0;
        c_w   = 1'b0;
        v_w   = 1'b0;
        def_w = 1'b1;
        case (alus)
            4'b0000: res_w = '0;
            4'b0001: begin
                sum_w = {1'b0, ac_n} + {1'b0, bus_n};
                res_w = sum_w[WIDTH-1:0];
                c_w   = sum_w[WIDTH];
                v_w   = (ac_n[M] == bus_n[M]) && (res_w[M] != ac_n[M]);
            end
            4'b0010: begin
                // Zero-extended difference: top bit is the borrow
                sum_w = {1'b0, ac_n} - {1'b0, bus_n};
                res_w = sum_w[WIDTH-1:0];
                c_w   = sum_w[WIDTH];
                v_w   = (ac_n[M] != bus_n[M]) && (res_w[M] != ac_n[M]);
            end
            4'b0011: begin
                sum_w = {1'b0, ac_n} + (WIDTH+1)'(1);
                res_w = sum_w[WIDTH-1:0];
                c_w   = sum_w[WIDTH];
                v_w   = ~ac_n[M] & res_w[M];
            end
            4'b0100: res_w = ac_n & bus_n;
            4'b0101: res_w = ac_n | bus_n;
            4'b0110: res_w = ~ac_n;
            4'b0111: res_w = ac_n ^ bus_n;
            4'b1000: res_w = bus_n;
            4'b1001: res_w = '0;
            4'b1010: begin
                res_w = {ac_n[WIDTH-2:0], 1'b0};
                c_w   = ac_n[M];
            end
            4'b1011: begin
                res_w = {1'b0, ac_n[WIDTH-1:1]};
                c_w   = ac_n[0];
            end
            default: def_w = 1'b0;
        endcase
    end

    // Next-state: accept requests in IDLE, iterate shift-add in MUL
    always_comb begin
        state_d  = state_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        prod_w   = acc_q + (mplier_q[0] ? mcand_q : '0);
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (alus == 4'b1001) begin
                        mcand_d  = {{WIDTH{1'b0}}, ac_n};
                        mplier_d = bus_n;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = MUL;
                    end else if (def_w) begin
                        dout_d  = res_w;
                        zero_d  = (res_w == '0);
                        neg_d   = res_w[M];
                        carry_d = c_w;
                        ovf_d   = v_w;
                        done_d  = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = prod_w;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    dout_d  = prod_w[WIDTH-1:0];
                    zero_d  = (prod_w[WIDTH-1:0] == '0);
                    neg_d   = prod_w[M];
                    carry_d = |prod_w[2*WIDTH-1:WIDTH];
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            dout_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign Dout  = dout_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign zero  = zero_q;
    assign neg   = neg_q;
    assign carry = carry_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8).
// Hand-computed expectations checked with immediate assertions.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] alus;
    logic [7:0] ac_n;
    logic [7:0] bus_n;
    logic [7:0] Dout;
    logic       busy;
    logic       done;
    logic       err;
    logic       zero;
    logic       neg;
    logic       carry;
    logic       ovf;

    int compared = 0;
    int mismatched = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .alus  (alus),
        .ac_n  (ac_n),
        .bus_n (bus_n),
        .Dout  (Dout),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .zero  (zero),
        .neg   (neg),
        .carry (carry),
        .ovf   (ovf)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check every output: Dout, zero, neg, carry, ovf, busy, done, err
    task automatic expect_all(input string tag, input logic [7:0] d,
                              input logic z, input logic n,
                              input logic c, input logic v,
                              input logic b, input logic dn,
                              input logic e);
        chk({tag, ".Dout"},  32'(Dout),  32'(d));
        chk({tag, ".zero"},  32'(zero),  32'(z));
        chk({tag, ".neg"},   32'(neg),   32'(n));
        chk({tag, ".carry"}, 32'(carry), 32'(c));
        chk({tag, ".ovf"},   32'(ovf),   32'(v));
        chk({tag, ".busy"},  32'(busy),  32'(b));
        chk({tag, ".done"},  32'(done),  32'(dn));
        chk({tag, ".err"},   32'(err),   32'(e));
    endtask

    // Present a request on the falling edge, return 1 after the sampling edge
    task automatic op(input logic [3:0] s, input logic [7:0] a,
                      input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        alus  = s;
        ac_n  = a;
        bus_n = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        start = 1'b0;
        alus  = 4'h0;
        ac_n  = 8'h00;
        bus_n = 8'h00;
        rst   = 1'b1;
        #1;
        expect_all("reset0", 8'h00, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ADD wrap
        op(4'b0001, 8'hFF, 8'h01);
        expect_all("add_ff_01", 8'h00, 1, 0, 1, 0, 0, 1, 0);
        tick();
        expect_all("add_ff_01_after", 8'h00, 1, 0, 1, 0, 0, 0, 0);

        op(4'b0001, 8'h7F, 8'h01);
        expect_all("add_ovf", 8'h80, 0, 1, 0, 1, 0, 1, 0);

        // SUB cases (back-to-back: issued during the done cycle)
        op(4'b0010, 8'h80, 8'h01);
        expect_all("sub_80_01", 8'h7F, 0, 0, 0, 1, 0, 1, 0);
        op(4'b0010, 8'h01, 8'h02);
        expect_all("sub_01_02", 8'hFF, 0, 1, 1, 0, 0, 1, 0);

        // INC
        op(4'b0011, 8'h7F, 8'h00);
        expect_all("inc_7f", 8'h80, 0, 1, 0, 1, 0, 1, 0);
        op(4'b0011, 8'hFF, 8'h00);
        expect_all("inc_ff", 8'h00, 1, 0, 1, 0, 0, 1, 0);

        // Logic
        op(4'b0100, 8'hF0, 8'h3C);
        expect_all("and", 8'h30, 0, 0, 0, 0, 0, 1, 0);
        op(4'b0101, 8'hF0, 8'h0C);
        expect_all("or", 8'hFC, 0, 1, 0, 0, 0, 1, 0);
        op(4'b0110, 8'h0F, 8'h00);
        expect_all("not", 8'hF0, 0, 1, 0, 0, 0, 1, 0);
        op(4'b0111, 8'hAA, 8'hAA);
        expect_all("xor", 8'h00, 1, 0, 0, 0, 0, 1, 0);
        op(4'b1000, 8'h00, 8'h81);
        expect_all("passb", 8'h81, 0, 1, 0, 0, 0, 1, 0);

        // Shifts
        op(4'b1010, 8'h81, 8'h00);
        expect_all("shl", 8'h02, 0, 0, 1, 0, 0, 1, 0);
        op(4'b1011, 8'h81, 8'h00);
        expect_all("shr", 8'h40, 0, 0, 1, 0, 0, 1, 0);
        op(4'b1011, 8'h02, 8'h00);
        expect_all("shr_nc", 8'h01, 0, 0, 0, 0, 0, 1, 0);

        // Clear
        op(4'b0000, 8'h55, 8'h66);
        expect_all("clear", 8'h00, 1, 0, 0, 0, 0, 1, 0);
        tick();

        // MUL 0x10*0x11 = 0x110, with an ignored start while busy
        op(4'b1001, 8'h10, 8'h11);
        expect_all("mul_e0", 8'h00, 1, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k < 8; k++) begin
            if (k == 3) begin
                @(negedge clk);
                start = 1'b1;
                alus  = 4'b0001;
                ac_n  = 8'h01;
                bus_n = 8'h01;
                @(posedge clk);
                #1;
                start = 1'b0;
            end else begin
                tick();
            end
            chk($sformatf("mul_busy_e%0d", k), 32'(busy), 32'd1);
            chk($sformatf("mul_nodone_e%0d", k), 32'(done), 32'd0);
        end
        tick();
        expect_all("mul_e8", 8'h10, 0, 0, 1, 0, 0, 1, 0);
        tick();
        expect_all("mul_e9", 8'h10, 0, 0, 1, 0, 0, 0, 0);

        // MUL with no upper bits: 0x0F*0x11 = 0x00FF
        op(4'b1001, 8'h0F, 8'h11);
        for (int k = 1; k < 8; k++) tick();
        chk("mul2_busy_e7", 32'(busy), 32'd1);
        tick();
        expect_all("mul2_e8", 8'hFF, 0, 1, 0, 0, 0, 1, 0);

        // Reset asynchronously in the middle of a multiply
        op(4'b1001, 8'h03, 8'h03);
        tick();
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        expect_all("rst_mid_mul", 8'h00, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("post_rst_nodone_%0d", k), 32'(done), 32'd0);
        end
        chk("post_rst_busy", 32'(busy), 32'd0);
        op(4'b0001, 8'h02, 8'h03);
        expect_all("add_2_3", 8'h05, 0, 0, 0, 0, 0, 1, 0);

        // Undefined code keeps Dout and flags
        op(4'b0010, 8'h59, 8'hFF);
        expect_all("sub_59_ff", 8'h5A, 0, 0, 1, 0, 0, 1, 0);
        tick();
        op(4'b1111, 8'h12, 8'h34);
        expect_all("undef_f", 8'h5A, 0, 0, 1, 0, 0, 1, 1);
        tick();
        expect_all("undef_after", 8'h5A, 0, 0, 1, 0, 0, 0, 0);
        op(4'b1100, 8'h00, 8'h00);
        expect_all("undef_c", 8'h5A, 0, 0, 1, 0, 0, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
